axi_rd_arbiter: RTL

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter
// Description : Two-master (IFU = m0, LSU = m1) AXI read-channel arbiter onto
//               a single slave. One transaction outstanding at a time,
//               round-robin between simultaneous requests.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,

  // IFU master
  input  logic              m0_ARVALID,
  input  logic [ADDR_W-1:0] m0_ARADDR,
  input  logic              m0_RREADY,
  output logic              m0_ARREADY,
  output logic              m0_RVALID,
  output logic [DATA_W-1:0] m0_RDATA,
  output logic [1:0]        m0_RRESP,

  // LSU master
  input  logic              m1_ARVALID,
  input  logic [ADDR_W-1:0] m1_ARADDR,
  input  logic              m1_RREADY,
  output logic              m1_ARREADY,
  output logic              m1_RVALID,
  output logic [DATA_W-1:0] m1_RDATA,
  output logic [1:0]        m1_RRESP,

  // shared slave
  output logic              s_ARVALID,
  output logic [ADDR_W-1:0] s_ARADDR,
  output logic              s_RREADY,
  input  logic              s_ARREADY,
  input  logic              s_RVALID,
  input  logic [DATA_W-1:0] s_RDATA,
  input  logic [1:0]        s_RRESP,

  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] addr_r;
  logic              gnt_r;     // master owning the outstanding transaction
  logic              last_gnt;  // most recent grant, for round-robin
  logic              gnt_sel;   // master chosen this cycle when granting
  logic              grant;     // AR handshake with a master this cycle
  logic              in_addr;
  logic              in_data;
  logic              sel_m0;
  logic              sel_m1;

  // Arbitration: a lone requester wins; on a tie the master not granted last time wins.
  always_comb begin
    gnt_sel = 1'b0;
    if (m0_ARVALID && m1_ARVALID) begin
      gnt_sel = ~last_gnt;
    end else begin
      gnt_sel = m1_ARVALID;
    end
  end

  // Every output is forced idle while rst is high, so gating is folded in here.
  assign grant   = (state_r == S_IDLE) && (m0_ARVALID || m1_ARVALID) && !rst;
  assign in_addr = (state_r == S_ADDR) && !rst;
  assign in_data = (state_r == S_DATA) && !rst;
  assign sel_m0  = in_data && !gnt_r;
  assign sel_m1  = in_data &&  gnt_r;

  assign m0_ARREADY = grant && !gnt_sel;
  assign m1_ARREADY = grant &&  gnt_sel;

  assign s_ARVALID = in_addr;
  assign s_ARADDR  = addr_r;
  assign s_RREADY  = in_data && (gnt_r ? m1_RREADY : m0_RREADY);

  // Read data is steered to the owner only; the other master sees all zeros.
  assign m0_RVALID = sel_m0 && s_RVALID;
  assign m0_RDATA  = sel_m0 ? s_RDATA : '0;
  assign m0_RRESP  = sel_m0 ? s_RRESP : 2'b00;
  assign m1_RVALID = sel_m1 && s_RVALID;
  assign m1_RDATA  = sel_m1 ? s_RDATA : '0;
  assign m1_RRESP  = sel_m1 ? s_RRESP : 2'b00;

  assign busy = (state_r != S_IDLE) && !rst;

  // Next-state: IDLE -> ADDR on grant, ADDR -> DATA on slave AR handshake,
  // DATA -> IDLE on slave R handshake; every wait is unbounded.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      S_IDLE: if (grant)                  state_nxt = S_ADDR;
      S_ADDR: if (s_ARREADY)              state_nxt = S_DATA;
      S_DATA: if (s_RVALID && s_RREADY)   state_nxt = S_IDLE;
      default:                            state_nxt = S_IDLE;
    endcase
  end

  // State, captured address and grant bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      addr_r   <= '0;
      gnt_r    <= 1'b0;
      last_gnt <= 1'b0;
    end else begin
      state_r <= state_nxt;
      if (grant) begin
        addr_r   <= gnt_sel ? m1_ARADDR : m0_ARADDR;
        gnt_r    <= gnt_sel;
        last_gnt <= gnt_sel;
      end
    end
  end

endmodule
`default_nettype wire
